// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 cache port between the L1 I-cache (0) and
// L1 D-cache (1); the winner owns the port for one full block fill or write-back.
module l2_port_arbiter #(
    parameter int ADDR_W      = 24,
    parameter int BLOCK_WORDS = 16,
    parameter int CNT_W       = 32
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic [1:0]        req_i,
    input  logic [1:0]        rw_i,
    input  logic [ADDR_W-1:0] add0_i,
    input  logic [ADDR_W-1:0] add1_i,
    input  logic [31:0]       data0_i,
    input  logic [31:0]       data1_i,
    output logic [1:0]        gnt_o,
    output logic [31:0]       rd_data_o,
    output logic [1:0]        rd_valid_o,
    output logic [1:0]        wack_o,
    output logic [1:0]        done_o,
    output logic              l2_req_o,
    output logic              l2_rw_o,
    output logic [ADDR_W-1:0] l2_add_o,
    output logic [31:0]       l2_data_o,
    input  logic              l2_ready_i,
    input  logic              l2_valid_i,
    input  logic [31:0]       l2_data_i,
    input  logic              l2_wack_i,
    input  logic              l2_done_i,
    output logic [CNT_W-1:0]  gnt_cnt0_o,
    output logic [CNT_W-1:0]  gnt_cnt1_o,
    output logic              busy_o,
    output logic              err_o
);

    // Handshakes: a requester holds req_i (with rw/address) until its done_o pulse;
    // gnt_o pulses once on acceptance. Toward L2, l2_req_o is held until the
    // one-cycle l2_ready_i; each l2_valid_i / l2_wack_i is one beat, and
    // l2_done_i closes the transaction after the last beat.

    localparam int BEAT_W = $clog2(BLOCK_WORDS) + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        BURST     = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              owner;
    logic              rw_q;
    logic [ADDR_W-1:0] add_q;
    logic              last_gnt;
    logic [BEAT_W-1:0] beat_cnt;

    logic win;
    logic win_id;
    logic beat;
    logic last_beat;
    logic in_write;
    logic proto_err;

    always_comb begin
        win    = (state == IDLE) && (req_i != 2'b00);
        win_id = 1'b0;
        case (req_i)
            2'b01:   win_id = 1'b0;
            2'b10:   win_id = 1'b1;
            2'b11:   win_id = ~last_gnt;
            default: win_id = 1'b0;
        endcase
    end

    // A beat is a fill word for reads and a consumed write word for write-backs.
    assign beat      = (state == BURST) && (rw_q ? l2_wack_i : l2_valid_i);
    assign last_beat = beat && (beat_cnt == BEAT_W'(BLOCK_WORDS - 1));
    assign in_write  = (state == BURST) && rw_q;

    assign proto_err = ((l2_valid_i || l2_wack_i) && (state != BURST))
                     || ((state == BURST) && rw_q && l2_valid_i)
                     || ((state == BURST) && !rw_q && l2_wack_i)
                     || (l2_done_i && (state != WAIT_DONE));

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        l2_req_o  = 1'b0;
        l2_rw_o   = 1'b0;
        l2_add_o  = '0;
        l2_data_o = '0;
        wack_o    = 2'b00;
        busy_o    = (state != IDLE);
        case (state)
            IDLE: begin
                if (win) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                l2_req_o = 1'b1;
                l2_rw_o  = rw_q;
                l2_add_o = add_q;
                if (l2_ready_i) begin
                    state_nxt = BURST;
                end
            end
            BURST: begin
                if (in_write) begin
                    l2_data_o     = owner ? data1_i : data0_i;
                    wack_o[owner] = l2_wack_i;
                end
                if (last_beat) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (l2_done_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            owner      <= 1'b0;
            rw_q       <= 1'b0;
            add_q      <= '0;
            last_gnt   <= 1'b1;
            beat_cnt   <= '0;
            gnt_o      <= 2'b00;
            rd_data_o  <= '0;
            rd_valid_o <= 2'b00;
            done_o     <= 2'b00;
        end else begin
            gnt_o      <= 2'b00;
            rd_valid_o <= 2'b00;
            done_o     <= 2'b00;
            if (win) begin
                owner <= win_id;
                rw_q  <= rw_i[win_id];
                add_q <= win_id ? add1_i : add0_i;
                gnt_o <= win_id ? 2'b10 : 2'b01;
            end
            if ((state == ISSUE) && l2_ready_i) begin
                beat_cnt <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (beat && !rw_q) begin
                rd_data_o  <= l2_data_i;
                rd_valid_o <= owner ? 2'b10 : 2'b01;
            end
            // Pointer moves only at completion so an aborted burst does not cost a turn.
            if ((state == WAIT_DONE) && l2_done_i) begin
                done_o   <= owner ? 2'b10 : 2'b01;
                last_gnt <= owner;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            gnt_cnt0_o <= '0;
            gnt_cnt1_o <= '0;
            err_o      <= 1'b0;
        end else begin
            if (gnt_o[0] && (gnt_cnt0_o != {CNT_W{1'b1}})) begin
                gnt_cnt0_o <= gnt_cnt0_o + 1'b1;
            end
            if (gnt_o[1] && (gnt_cnt1_o != {CNT_W{1'b1}})) begin
                gnt_cnt1_o <= gnt_cnt1_o + 1'b1;
            end
            if (proto_err) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule
